// File: rtl/pwm_duty_decoder.sv
// PWM receive-side decoder: measures period and high time in clk cycles and reports duty in tenths.
// Define PWM_DEC_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizer.
module pwm_duty_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [3:0]       duty_tenths,
    output logic             valid,
    output logic             stuck
);
    localparam int unsigned PROD_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic sync1_q, sync2_q;
    logic s, s_q;
    logic rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic hist0_q, hist1_q, filt_q;

    // s only moves once two of the last three synchronized samples agree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0_q <= 1'b0;
            hist1_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist0_q <= sync2_q;
            hist1_q <= hist0_q;
            filt_q  <= (sync2_q & hist0_q) | (sync2_q & hist1_q) | (hist0_q & hist1_q);
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s;
        end
    end

    assign rise = s & ~s_q;
    assign fall = ~s & s_q;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  high_cap_q;
    logic              cnt_sat;
    logic              accept_rise;
    logic              cap_en;
    logic              cap_stuck;
    logic [CNT_W-1:0]  cap_high;
    logic [PROD_W-1:0] cap_prod;

    logic              s1_valid_q;
    logic              s1_stuck_q;
    logic [CNT_W-1:0]  s1_period_q;
    logic [CNT_W-1:0]  s1_high_q;
    logic [PROD_W-1:0] s1_prod_q;
    logic [3:0]        duty_d;

    // Capture decode; a saturated counter wins over any edge seen in the same cycle.
    always_comb begin
        cnt_sat     = (cnt_q == CntMax);
        accept_rise = 1'b0;
        cap_en      = 1'b0;
        cap_stuck   = 1'b0;
        cap_high    = high_cap_q;
        case (state_q)
            StIdle: begin
                accept_rise = rise;
            end
            StHigh: begin
                if (cnt_sat) begin
                    cap_en    = 1'b1;
                    cap_stuck = 1'b1;
                    cap_high  = CntMax;
                end
            end
            StLow: begin
                if (cnt_sat) begin
                    cap_en    = 1'b1;
                    cap_stuck = 1'b1;
                end else if (rise) begin
                    cap_en      = 1'b1;
                    accept_rise = 1'b1;
                end
            end
            default: begin
                accept_rise = 1'b0;
            end
        endcase

        if (accept_rise) begin
            cnt_d = CntOne;
        end else if (cnt_sat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntOne;
        end

        cap_prod = ({4'b0000, cap_high} << 3) + ({4'b0000, cap_high} << 1);
    end

    // Quantize without a divider: count the multiples k*period that fit under 10*high.
    always_comb begin
        duty_d = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            if (PROD_W'(s1_period_q) * PROD_W'(k) <= s1_prod_q) begin
                duty_d = duty_d + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            high_cap_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_stuck_q  <= 1'b0;
            s1_period_q <= '0;
            s1_high_q   <= '0;
            s1_prod_q   <= '0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            duty_tenths <= 4'd0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
        end else if (!ena) begin
            // Drop the measurement and anything in flight; result outputs keep their values.
            state_q    <= StIdle;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            valid      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= cap_en;
            valid      <= s1_valid_q;

            if (cap_en) begin
                s1_period_q <= cnt_q;
                s1_high_q   <= cap_high;
                s1_prod_q   <= cap_prod;
                s1_stuck_q  <= cap_stuck;
            end

            if (s1_valid_q) begin
                period_cnt  <= s1_period_q;
                high_cnt    <= s1_high_q;
                duty_tenths <= duty_d;
                stuck       <= s1_stuck_q;
            end

            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StHigh;
                    end
                end
                StHigh: begin
                    if (cnt_sat) begin
                        state_q <= StIdle;
                    end else if (fall) begin
                        high_cap_q <= cnt_q;
                        state_q    <= StLow;
                    end
                end
                StLow: begin
                    if (cnt_sat) begin
                        state_q <= StIdle;
                    end else if (rise) begin
                        state_q <= StHigh;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder (CNT_W=8): timestamp-based measurement model plus
// directed literal checks.
module tb_pwm_duty_decoder;
    localparam int unsigned W = 8;
    localparam int MAXC = 255;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int EdgeLat = 4;
    localparam int HMin = 2;
    localparam int HMax = 8;
`else
    localparam int EdgeLat = 2;
    localparam int HMin = 1;
    localparam int HMax = 9;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ena = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] period_cnt;
    logic [W-1:0] high_cnt;
    logic [3:0]   duty_tenths;
    logic         valid;
    logic         stuck;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .CNT_W(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .duty_tenths(duty_tenths),
        .valid      (valid),
        .stuck      (stuck)
    );

    typedef struct {
        int t;
        int per;
        int hi;
        int duty;
        bit stk;
    } res_t;

    res_t pend[$];
    res_t held;
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   in_high = 1'b0;
    int   rise_t = 0;
    int   high_len = 0;
    bit   p1, p2, p3, p4, p5, s_prev;

    int nvalid = 0;
    int nstuck = 0;
    int stuck_cyc = -1;
    int first_v = -1;
    int mark = 0;
    bit gwin = 1'b0;
    int nsplit = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int t, input int per, input int hi, input bit stk);
        res_t r;
        r.t    = t;
        r.per  = per;
        r.hi   = hi;
        r.duty = (10 * hi) / per;
        r.stk  = stk;
        pend.push_back(r);
    endfunction

    // Model: s is pwm_in delayed through the synchronizer (and majority filter); a result is
    // due 2 cycles after the cycle in which its closing edge or timeout is seen on s.
    initial begin : model_and_compare
        bit s_now;
        bit rise;
        bit fall;
        bit ev;
        held = '{t: 0, per: 0, hi: 0, duty: 0, stk: 1'b0};
        {p1, p2, p3, p4, p5, s_prev} = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_valid", int'(valid), 0);
                check("rst_period", int'(period_cnt), 0);
                check("rst_high", int'(high_cnt), 0);
                check("rst_duty", int'(duty_tenths), 0);
                check("rst_stuck", int'(stuck), 0);
                pend.delete();
                armed   = 1'b0;
                in_high = 1'b0;
                held    = '{t: 0, per: 0, hi: 0, duty: 0, stk: 1'b0};
                {p1, p2, p3, p4, p5, s_prev} = '0;
            end else begin
                ev = (pend.size() > 0) && (pend[0].t == cyc);
                if (ev) held = pend.pop_front();
                check("valid", int'(valid), int'(ev));
                check("period_cnt", int'(period_cnt), held.per);
                check("high_cnt", int'(high_cnt), held.hi);
                check("duty_tenths", int'(duty_tenths), held.duty);
                check("stuck", int'(stuck), int'(held.stk));
                if (valid) begin
                    nvalid++;
                    if (stuck) nstuck++;
                    if (stuck && stuck_cyc < 0) stuck_cyc = cyc;
                    if (first_v < 0 && cyc >= mark) first_v = cyc;
                    if (gwin && period_cnt != 8'd20) nsplit++;
                end

`ifdef PWM_DEC_GLITCH_FILTER_EN
                s_now = (p3 & p4) | (p3 & p5) | (p4 & p5);
`else
                s_now = p2;
`endif
                rise = s_now && !s_prev;
                fall = !s_now && s_prev;
                if (!ena) begin
                    armed = 1'b0;
                    pend.delete();
                end else if (armed && (cyc - rise_t) == MAXC) begin
                    if (in_high) push(cyc + 2, MAXC, MAXC, 1'b1);
                    else push(cyc + 2, MAXC, high_len, 1'b1);
                    armed = 1'b0;
                end else if (armed && in_high && fall) begin
                    high_len = cyc - rise_t;
                    in_high  = 1'b0;
                end else if (rise) begin
                    if (armed && !in_high) push(cyc + 2, cyc - rise_t, high_len, 1'b0);
                    armed   = 1'b1;
                    in_high = 1'b1;
                    rise_t  = cyc;
                end
                p5 = p4;
                p4 = p3;
                p3 = p2;
                p2 = p1;
                p1 = pwm_in;
                s_prev = s_now;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < per; i++) begin
                pwm_in = (i < hi);
                step();
            end
        end
    endtask

    task automatic drive_glitch(input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < 20; i++) begin
                pwm_in = (i < 8) || (i == 14);
                step();
            end
        end
    endtask

    task automatic check_out(input string tag, input int per, input int hi, input int duty,
                             input int stk);
        check({tag, "_period"}, int'(period_cnt), per);
        check({tag, "_high"}, int'(high_cnt), hi);
        check({tag, "_duty"}, int'(duty_tenths), duty);
        check({tag, "_stuck"}, int'(stuck), stk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int seg;
        #1 rst_n = 1'b0;
        repeat (3) step();
        check_out("reset", 0, 0, 0, 0);
        check("reset_valid", int'(valid), 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (2) step();

        // Loopback-style period 10 / duty 5: four results in four steady periods.
        drive(10, 5, 2);
        nvalid = 0;
        drive(10, 5, 4);
        check("loop_nvalid", nvalid, 4);
        check_out("loop", 10, 5, 5, 0);

        // Duty sweep over period 10.
        for (int h = 0; h < 10; h++) begin
            nvalid = 0;
            drive(10, h, 4);
            if (h == 0) check("sweep0_nvalid", nvalid, 0);
            if (h >= HMin && h <= HMax) check_out("sweep", 10, h, h, 0);
        end

        // Held high: a single stuck result, 2 sync + 255 count + 2 pipeline cycles later.
        pwm_in    = 1'b1;
        seg       = cyc;
        stuck_cyc = -1;
        nstuck    = 0;
        nvalid    = 0;
        repeat (300) step();
        check("hold_nstuck", nstuck, 1);
`ifndef PWM_DEC_GLITCH_FILTER_EN
        check("hold_nvalid", nvalid, 2);
        check("hold_latency", stuck_cyc - seg, EdgeLat + MAXC + 2);
`endif
        check_out("hold", 255, 255, 10, 1);

        // Period 7 / high 3 clears stuck; floor(30/7) = 4.
        drive(7, 3, 5);
        check_out("p7", 7, 3, 4, 0);

        // Held low after a measured high phase: timeout in LOW keeps high_cap.
        pwm_in = 1'b0;
        repeat (270) step();
        check_out("lowto", 255, 3, 0, 1);

        // ena drop in the middle of a HIGH phase.
        drive(10, 5, 4);
        pwm_in = 1'b1;
        repeat (3) step();
        ena = 1'b0;
        repeat (2) step();
        pwm_in = 1'b0;
        check("ena_valid", int'(valid), 0);
        check_out("ena_hold", 10, 5, 5, 0);
        repeat (6) step();
        ena     = 1'b1;
        mark    = cyc;
        first_v = -1;
        drive(10, 5, 3);
        check("ena_first", first_v - mark, EdgeLat + 10 + 2);
        check_out("ena_after", 10, 5, 5, 0);

        // Reset pulse in the middle of a HIGH phase.
        drive(10, 5, 3);
        pwm_in = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_out("midrst", 0, 0, 0, 0);
        repeat (2) step();
        pwm_in = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        mark    = cyc;
        first_v = -1;
        drive(10, 5, 3);
        check("rst_first", first_v - mark, EdgeLat + 10 + 2);
        check_out("rst_after", 10, 5, 5, 0);

        // One-cycle glitch in the low phase of period 20 / high 8.
        drive(20, 8, 3);
        nsplit = 0;
        gwin   = 1'b1;
        drive_glitch(2);
        drive(20, 8, 2);
        gwin = 1'b0;
`ifdef PWM_DEC_GLITCH_FILTER_EN
        check("glitch_nsplit", nsplit, 0);
`else
        check("glitch_split", int'(nsplit > 0), 1);
`endif
        check_out("glitch_end", 20, 8, 4, 0);

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
